// File: rtl/block_mode_stream_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : block_mode_stream_engine                                       |
// | Purpose  : Streaming ECB/CBC/CTR block-mode engine. Accepts one block at  |
// |            a time on a valid/ready input stream, drives an external       |
// |            block-cipher core through a start/done handshake and emits     |
// |            the result on a valid/ready output stream.                     |
// | Options  : define MODE_OFB_EN to enable OFB on mode 2'b11; otherwise     |
// |            mode 2'b11 is rejected with err + done and no core activity.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module block_mode_stream_engine #(
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_SIZE   = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  decrypt,
  input  logic [KEY_SIZE-1:0]   key,
  input  logic [BLOCK_SIZE-1:0] iv_nonce,
  input  logic [LEN_WIDTH-1:0]  num_blocks,
  input  logic [BLOCK_SIZE-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BLOCK_SIZE-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_SIZE-1:0] core_block,
  output logic [KEY_SIZE-1:0]   core_key,
  output logic                  core_inverse,
  output logic                  core_start,
  input  logic [BLOCK_SIZE-1:0] core_result,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] C_MODE_ECB = 2'b00;
  localparam logic [1:0] C_MODE_CBC = 2'b01;
  localparam logic [1:0] C_MODE_CTR = 2'b10;
  localparam logic [1:0] C_MODE_OFB = 2'b11;

  // Selects the counter field (low CNT_WIDTH bits) of the CTR counter block.
  localparam logic [BLOCK_SIZE-1:0] C_CNT_MASK =
    (BLOCK_SIZE'(1) << CNT_WIDTH) - BLOCK_SIZE'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_IN    = 3'd1,
    S_CORE_REQ  = 3'd2,
    S_CORE_WAIT = 3'd3,
    S_PUT_OUT   = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t                state_q,   state_d;
  logic [1:0]            mode_q,    mode_d;
  logic                  decrypt_q, decrypt_d;
  logic                  err_q,     err_d;
  logic [KEY_SIZE-1:0]   key_q,     key_d;
  logic [BLOCK_SIZE-1:0] chain_q,   chain_d;
  logic [BLOCK_SIZE-1:0] x_q,       x_d;
  logic [BLOCK_SIZE-1:0] out_q,     out_d;
  logic [LEN_WIDTH-1:0]  remain_q,  remain_d;

  logic                  mode_ok;
  logic [CNT_WIDTH-1:0]  ctr_low_inc;
  logic [BLOCK_SIZE-1:0] ctr_next;

`ifdef MODE_OFB_EN
  assign mode_ok = 1'b1;
`else
  assign mode_ok = (mode != C_MODE_OFB);
`endif

  // Counter update touches only the low CNT_WIDTH bits; the nonce part is kept.
  assign ctr_low_inc = chain_q[CNT_WIDTH-1:0] + CNT_WIDTH'(1);
  assign ctr_next    = (chain_q & ~C_CNT_MASK) | BLOCK_SIZE'(ctr_low_inc);

  // Block presented to the cipher core, selected by the latched mode.
  always_comb begin
    core_block = x_q;
    case (mode_q)
      C_MODE_CBC: if (!decrypt_q) core_block = x_q ^ chain_q;
      C_MODE_CTR,
      C_MODE_OFB: core_block = chain_q;
      default:    core_block = x_q;
    endcase
  end

  // Moore outputs decoded from the state and latched job settings.
  assign in_ready     = (state_q == S_GET_IN);
  assign core_start   = (state_q == S_CORE_REQ);
  assign out_valid    = (state_q == S_PUT_OUT);
  assign done         = (state_q == S_FINISH);
  assign err          = (state_q == S_FINISH) && err_q;
  assign busy         = (state_q != S_IDLE);
  assign out_data     = out_q;
  assign core_key     = key_q;
  assign core_inverse = decrypt_q && ((mode_q == C_MODE_ECB) || (mode_q == C_MODE_CBC));

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    decrypt_d = decrypt_q;
    err_d     = err_q;
    key_d     = key_q;
    chain_d   = chain_q;
    x_d       = x_q;
    out_d     = out_q;
    remain_d  = remain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode;
          decrypt_d = decrypt;
          key_d     = key;
          chain_d   = iv_nonce;
          remain_d  = num_blocks;
          err_d     = !mode_ok;
          if (!mode_ok || (num_blocks == '0)) state_d = S_FINISH;
          else                                state_d = S_GET_IN;
        end
      end
      S_GET_IN: begin
        if (in_valid) begin
          x_d     = in_data;
          state_d = S_CORE_REQ;
        end
      end
      S_CORE_REQ: begin
        state_d = S_CORE_WAIT;
      end
      S_CORE_WAIT: begin
        if (core_done) begin
          state_d = S_PUT_OUT;
          case (mode_q)
            C_MODE_CBC: begin
              if (decrypt_q) begin
                out_d   = core_result ^ chain_q;
                chain_d = x_q;
              end else begin
                out_d   = core_result;
                chain_d = core_result;
              end
            end
            C_MODE_CTR: begin
              out_d   = x_q ^ core_result;
              chain_d = ctr_next;
            end
            C_MODE_OFB: begin
              out_d   = x_q ^ core_result;
              chain_d = core_result;
            end
            default: out_d = core_result;
          endcase
        end
      end
      S_PUT_OUT: begin
        if (out_ready) begin
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) state_d = S_FINISH;
          else                           state_d = S_GET_IN;
        end
      end
      S_FINISH: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      decrypt_q <= 1'b0;
      err_q     <= 1'b0;
      key_q     <= '0;
      chain_q   <= '0;
      x_q       <= '0;
      out_q     <= '0;
      remain_q  <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      decrypt_q <= decrypt_d;
      err_q     <= err_d;
      key_q     <= key_d;
      chain_q   <= chain_d;
      x_q       <= x_d;
      out_q     <= out_d;
      remain_q  <= remain_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_mode_stream_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_block_mode_stream_engine                                    |
// | Purpose  : Directed self-checking bench for block_mode_stream_engine      |
// |            with a stub core: result = block ^ key, latency 3 cycles.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_block_mode_stream_engine;

  localparam int BS = 64;
  localparam int KS = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          decrypt = 1'b0;
  logic [KS-1:0] key = '0;
  logic [BS-1:0] iv_nonce = '0;
  logic [LW-1:0] num_blocks = '0;
  logic [BS-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BS-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BS-1:0] core_block;
  logic [KS-1:0] core_key;
  logic          core_inverse;
  logic          core_start;
  logic [BS-1:0] core_result;
  logic          core_done;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  int n_core_start = 0;
  int n_done = 0;

  logic [BS-1:0] in_blk  [4];
  logic [BS-1:0] exp_blk [4];

  // Stub cipher core.
  logic [BS-1:0] stub_res = '0;
  logic [2:0]    stub_pipe = '0;
  logic          spur_done = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    stub_pipe <= {stub_pipe[1:0], core_start};
    if (core_start) stub_res <= core_block ^ core_key;
    if (core_start) n_core_start <= n_core_start + 1;
    if (done)       n_done <= n_done + 1;
  end

  assign core_done   = stub_pipe[2] | spur_done;
  assign core_result = stub_res;

  block_mode_stream_engine #(
    .BLOCK_SIZE(BS), .KEY_SIZE(KS), .CNT_WIDTH(32), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .decrypt(decrypt),
    .key(key), .iv_nonce(iv_nonce), .num_blocks(num_blocks),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .core_block(core_block), .core_key(core_key), .core_inverse(core_inverse),
    .core_start(core_start), .core_result(core_result), .core_done(core_done),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Waits (bounded) at negedges until in_ready (which=0) or out_valid (which=1).
  task automatic wait_hi(input int which, input string tag);
    logic s;
    for (int i = 0; i < 50; i++) begin
      s = (which == 0) ? in_ready : out_valid;
      if (s === 1'b1) return;
      @(negedge clk);
    end
    check_eq({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Runs one job; blocks come from in_blk, expected outputs from exp_blk.
  task automatic run_job(input string tag, input logic [1:0] m, input logic dec,
                         input logic [63:0] k, input logic [63:0] iv, input int n,
                         input logic exp_inv, input int bp, input bit spur, input bit poke);
    int starts0;
    logic [63:0] hold;
    bit bp_ok;
    starts0 = n_core_start;
    mode = m; decrypt = dec; key = k; iv_nonce = iv; num_blocks = LW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      wait_hi(0, {tag, "_in_ready"});
      if (spur && i == 0) begin
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check_eq({tag, "_spur_in_ready"}, {63'd0, in_ready}, 64'd1);
        check_eq({tag, "_spur_out_valid"}, {63'd0, out_valid}, 64'd0);
      end
      in_valid = 1'b1; in_data = in_blk[i];
      @(negedge clk);
      in_valid = 1'b0; in_data = '0;
      check_eq({tag, "_core_start"}, {63'd0, core_start}, 64'd1);
      check_eq({tag, "_core_inverse"}, {63'd0, core_inverse}, {63'd0, exp_inv});
      if (poke && i == 0) begin
        start = 1'b1; mode = 2'b01; decrypt = 1'b1; num_blocks = 16'd7;
        iv_nonce = '1; key = '1;
      end
      @(negedge clk);
      start = 1'b0;
      check_eq({tag, "_start_one_cycle"}, {63'd0, core_start}, 64'd0);
      wait_hi(1, {tag, "_out_valid"});
      check_eq({tag, "_out_data"}, out_data, exp_blk[i]);
      if (bp > 0 && i == 0) begin
        hold = out_data;
        bp_ok = 1'b1;
        for (int c = 0; c < bp; c++) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || out_data !== hold || in_ready !== 1'b0) bp_ok = 1'b0;
        end
        check_eq({tag, "_bp_stable"}, {63'd0, bp_ok}, 64'd1);
        check_eq({tag, "_bp_no_start"}, 64'(n_core_start - starts0), 64'd1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check_eq({tag, "_done"}, {63'd0, done}, 64'd1);
    check_eq({tag, "_err"}, {63'd0, err}, 64'd0);
    check_eq({tag, "_core_starts"}, 64'(n_core_start - starts0), 64'(n));
    @(negedge clk);
    check_eq({tag, "_done_cleared"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {57'd0, in_ready, out_valid, core_inverse, core_start, busy, done, err}, 64'd0);
    check_eq("reset_out_data", out_data, 64'd0);
    check_eq("reset_core_key", core_key, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ECB encrypt.
    in_blk[0] = 64'h0123456789ABCDEF; exp_blk[0] = 64'h0E2C4A6886A4C2E0;
    run_job("ecb", 2'b00, 1'b0, 64'h0F0F0F0F0F0F0F0F, 64'd0, 1, 1'b0, 0, 1'b0, 1'b0);

    // CBC encrypt and decrypt.
    in_blk[0]  = 64'h2222222222222222; in_blk[1]  = 64'h3333333333333333;
    exp_blk[0] = 64'h3333333333333333; exp_blk[1] = 64'h0000000000000000;
    run_job("cbc_enc", 2'b01, 1'b0, 64'd0, 64'h1111111111111111, 2, 1'b0, 0, 1'b0, 1'b0);
    in_blk[0]  = 64'h3333333333333333; in_blk[1]  = 64'h0000000000000000;
    exp_blk[0] = 64'h2222222222222222; exp_blk[1] = 64'h3333333333333333;
    run_job("cbc_dec", 2'b01, 1'b1, 64'd0, 64'h1111111111111111, 2, 1'b1, 0, 1'b0, 1'b0);

    // CTR counter wrap; decrypt flag must not invert the core.
    in_blk[0]  = 64'd0; in_blk[1] = 64'd0;
    exp_blk[0] = 64'hAAAAAAAAFFFFFFFF; exp_blk[1] = 64'hAAAAAAAA00000000;
    run_job("ctr_wrap", 2'b10, 1'b1, 64'd0, 64'hAAAAAAAAFFFFFFFF, 2, 1'b0, 0, 1'b0, 1'b0);

    // Backpressure, spurious core_done in GET_IN, start while busy.
    in_blk[0] = 64'h5A5A5A5AA5A5A5A5; exp_blk[0] = 64'h5A5A5A5AA5A5A5A5 ^ 64'hC3C3C3C3C3C3C3C3;
    run_job("bp", 2'b00, 1'b0, 64'hC3C3C3C3C3C3C3C3, 64'd0, 1, 1'b0, 10, 1'b1, 1'b1);

    // Zero-length job.
    run_job("zero_len", 2'b00, 1'b0, 64'd0, 64'd0, 0, 1'b0, 0, 1'b0, 1'b0);

    // Mode 11.
    in_blk[0] = 64'd0; exp_blk[0] = 64'h1111111111111111;
`ifdef MODE_OFB_EN
    run_job("ofb", 2'b11, 1'b0, 64'd0, 64'h1111111111111111, 1, 1'b0, 0, 1'b0, 1'b0);
`else
    begin
      int s0;
      s0 = n_core_start;
      mode = 2'b11; decrypt = 1'b0; key = 64'd0; iv_nonce = 64'h1111111111111111;
      num_blocks = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("mode11_err_done", {62'd0, err, done}, 64'd3);
      @(negedge clk);
      check_eq("mode11_cleared", {61'd0, err, done, busy}, 64'd0);
      check_eq("mode11_no_core", 64'(n_core_start - s0), 64'd0);
    end
`endif

    // Reset asserted mid-CORE_WAIT.
    begin
      int d0;
      mode = 2'b00; decrypt = 1'b1; key = 64'h1234; iv_nonce = 64'h55;
      num_blocks = 16'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_hi(0, "rst_in_ready");
      in_valid = 1'b1; in_data = 64'hFEED;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      d0 = n_done;
      reset_n = 1'b0;
      #1;
      check_eq("midjob_reset_ctrl",
               {57'd0, in_ready, out_valid, core_inverse, core_start, busy, done, err}, 64'd0);
      check_eq("midjob_reset_data", out_data | core_block | core_key, 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      check_eq("midjob_reset_no_done", 64'(n_done - d0), 64'd0);
      check_eq("midjob_reset_idle", {63'd0, busy}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
